pipeline_stall_controller: RTL and testbench

Consumes the decode-stage `stall_stop` code (00 none, 01 insert bubble for FENCE/FENCE.I/ECALL, 10 halt for EBREAK) and turns it into cycle-accurate pipeline control: PC write enable, IF/ID enable and IF/ID flush, plus a sticky halted status. It sits between the decoder's special-instruction classifier and the PC/IF-ID pipeline registers. It also merges an external freeze request from the memory interface.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipeline_stall_controller_stall_timer.sv | 26 ++
 rtl/pipeline_stall_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared FSM state and decoder stall_stop encodings
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] SS_NONE = 2'b00;
  localparam logic [1:0] SS_NOP  = 2'b01;
  localparam logic [1:0] SS_HALT = 2'b10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_stall_timer.sv
// rtl/pipeline_stall_controller_stall_timer.sv - loadable down-counter with hold and count==1 flag
module stall_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - turns decode stall_stop codes into PC/IF-ID control
// Optional stall performance counter: STALL_PERF_CNT_EN.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int NOP_CYCLES   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       stall_stop,
  input  logic             ext_stall,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMR_MAX = max2(NOP_CYCLES, DRAIN_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t             state;
  state_t             state_nxt;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_load_val;
  logic               tmr_hold;
  logic [TMR_W-1:0]   tmr;
  logic               tmr_last;
  logic [1:0]         code;

  // A bubble in decode carries no meaningful code; 2'b11 falls through as none.
  assign code = id_valid ? stall_stop : SS_NONE;

  stall_timer #(.W(TMR_W)) u_stall_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .hold     (tmr_hold),
    .count    (tmr),
    .last     (tmr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_hold     = 1'b1;
    case (state)
      ST_RUN: begin
        if (code == SS_NOP) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          if (NOP_CYCLES > 1) begin
            state_nxt    = ST_STALL;
            tmr_load     = 1'b1;
            tmr_load_val = TMR_W'(NOP_CYCLES - 1);
          end
        end else if (code == SS_HALT) begin
          pc_en        = 1'b0;
          if_id_flush  = 1'b1;
          state_nxt    = ST_DRAIN;
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(DRAIN_CYCLES);
        end
      end
      ST_STALL: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        tmr_hold    = 1'b0;
        if (tmr_last) state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        tmr_hold    = 1'b0;
        if (tmr_last) state_nxt = ST_HALT;
      end
      ST_HALT: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        if (resume) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase

    // Memory freeze wins, but must not swallow the resume pulse out of HALT.
    if (ext_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      tmr_load    = 1'b0;
      tmr_hold    = 1'b1;
      if (state != ST_HALT) state_nxt = state;
    end
  end

  assign halted = (state == ST_HALT);

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!pc_en && state != ST_HALT && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed bench: u_a NOP=1/CNT_W=3, u_b NOP=3/CNT_W=32
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       id_valid;
  logic [1:0] stall_stop;
  logic       ext_stall;
  logic       resume;

  logic        pc_en_a, if_id_en_a, flush_a, halted_a;
  logic [2:0]  cnt_a;
  logic        pc_en_b, if_id_en_b, flush_b, halted_b;
  logic [31:0] cnt_b;

  int total = 0;
  int bad   = 0;
  int ea    = 0;
  int eb    = 0;

  pipeline_stall_controller #(.NOP_CYCLES(1), .DRAIN_CYCLES(3), .CNT_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall_stop(stall_stop),
    .ext_stall(ext_stall), .resume(resume), .pc_en(pc_en_a), .if_id_en(if_id_en_a),
    .if_id_flush(flush_a), .halted(halted_a), .stall_cnt(cnt_a)
  );

  pipeline_stall_controller #(.NOP_CYCLES(3), .DRAIN_CYCLES(3), .CNT_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall_stop(stall_stop),
    .ext_stall(ext_stall), .resume(resume), .pc_en(pc_en_b), .if_id_en(if_id_en_b),
    .if_id_flush(flush_b), .halted(halted_b), .stall_cnt(cnt_b)
  );

  function automatic logic [31:0] exp_cnt(input int n, input int w);
`ifdef STALL_PERF_CNT_EN
    int mx;
    mx = (w >= 32) ? 32'h7fffffff : ((1 << w) - 1);
    return (n > mx) ? mx : n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic p, input logic e, input logic f, input logic h);
    chk({tag, "_a_pc_en"}, 32'(pc_en_a), 32'(p));
    chk({tag, "_a_if_id_en"}, 32'(if_id_en_a), 32'(e));
    chk({tag, "_a_flush"}, 32'(flush_a), 32'(f));
    chk({tag, "_a_halted"}, 32'(halted_a), 32'(h));
  endtask

  task automatic chk_b(input string tag, input logic p, input logic e, input logic f, input logic h);
    chk({tag, "_b_pc_en"}, 32'(pc_en_b), 32'(p));
    chk({tag, "_b_if_id_en"}, 32'(if_id_en_b), 32'(e));
    chk({tag, "_b_flush"}, 32'(flush_b), 32'(f));
    chk({tag, "_b_halted"}, 32'(halted_b), 32'(h));
  endtask

  task automatic chk_ab(input string tag, input logic p, input logic e, input logic f, input logic h);
    chk_a(tag, p, e, f, h);
    chk_b(tag, p, e, f, h);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_a_cnt"}, 32'(cnt_a), exp_cnt(ea, 3));
    chk({tag, "_b_cnt"}, cnt_b, exp_cnt(eb, 32));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; stall_stop = 2'b00; ext_stall = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_ab("reset", 1, 1, 0, 0);
    chk_cnt("reset");
    rst_n = 1'b1;
    tick();
    #3 chk_ab("idle", 1, 1, 0, 0);
    tick();

    // 01 in cycle T, repeated in T+1: u_a bubbles again, u_b is already stalling
    id_valid = 1'b1; stall_stop = 2'b01;
    #3 chk_ab("nop_t0", 0, 1, 1, 0); ea++; eb++;
    tick();
    #3 chk_ab("nop_t1", 0, 1, 1, 0); ea++; eb++;
    tick();
    stall_stop = 2'b00;
    #3 chk_a("nop_t2", 1, 1, 0, 0); chk_b("nop_t2", 0, 1, 1, 0); eb++;
    tick();
    #3 chk_ab("nop_t3", 1, 1, 0, 0);
    chk_cnt("nop_done");
    tick();

    // masked codes
    stall_stop = 2'b11;
    #3 chk_ab("code11", 1, 1, 0, 0);
    tick();
    id_valid = 1'b0; stall_stop = 2'b01;
    #3 chk_ab("nop_novalid", 1, 1, 0, 0);
    tick();
    stall_stop = 2'b10;
    #3 chk_ab("halt_novalid", 1, 1, 0, 0);
    tick();
    stall_stop = 2'b00; resume = 1'b1;
    #3 chk_ab("resume_in_run", 1, 1, 0, 0);
    tick();
    resume = 1'b0;

    // freeze in RUN; a code presented under freeze is not sampled
    ext_stall = 1'b1;
    #3 chk_ab("frz_run", 0, 0, 0, 0); ea++; eb++;
    tick();
    id_valid = 1'b1; stall_stop = 2'b01;
    #3 chk_ab("frz_code", 0, 0, 0, 0); ea++; eb++;
    tick();
    ext_stall = 1'b0; id_valid = 1'b0; stall_stop = 2'b00;
    #3 chk_ab("frz_after", 1, 1, 0, 0);
    chk_cnt("frz_done");
    tick();

    // 10 -> drain 3 -> halt -> resume
    id_valid = 1'b1; stall_stop = 2'b10;
    #3 chk_ab("drain_t0", 0, 1, 1, 0); ea++; eb++;
    tick();
    id_valid = 1'b0; stall_stop = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      #3 chk_ab("drain_tn", 0, 1, 1, 0); ea++; eb++;
      tick();
    end
    #3 chk_ab("halt_t4", 0, 1, 1, 1);
    chk_cnt("halt_t4");
    tick();
    repeat (3) begin
      #3 chk_ab("halt_hold", 0, 1, 1, 1);
      tick();
    end
    chk_cnt("halt_hold");
    resume = 1'b1;
    #3 chk_ab("resume_h", 0, 1, 1, 1);
    tick();
    resume = 1'b0;
    #3 chk_ab("resume_h1", 1, 1, 0, 0);
    tick();

    // 10 with freeze on T+1, T+2: halt delayed by two cycles
    id_valid = 1'b1; stall_stop = 2'b10;
    #3 chk_ab("xdrain_t0", 0, 1, 1, 0); ea++; eb++;
    tick();
    id_valid = 1'b0; stall_stop = 2'b00; ext_stall = 1'b1;
    #3 chk_ab("xdrain_t1", 0, 0, 0, 0); ea++; eb++;
    tick();
    #3 chk_ab("xdrain_t2", 0, 0, 0, 0); ea++; eb++;
    tick();
    ext_stall = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      #3 chk_ab("xdrain_tn", 0, 1, 1, 0); ea++; eb++;
      tick();
    end
    #3 chk_ab("xhalt_t6", 0, 1, 1, 1);
    chk_cnt("xhalt_t6");
    tick();
    ext_stall = 1'b1; resume = 1'b1;
    #3 chk_ab("frz_resume", 0, 0, 0, 1);
    tick();
    ext_stall = 1'b0; resume = 1'b0;
    #3 chk_ab("frz_resume_h1", 1, 1, 0, 0);
    chk_cnt("frz_resume_h1");
    tick();

    // async reset mid-DRAIN
    id_valid = 1'b1; stall_stop = 2'b10;
    #3 chk_ab("rdrain_t0", 0, 1, 1, 0);
    tick();
    id_valid = 1'b0; stall_stop = 2'b00;
    #3 chk_ab("rdrain_t1", 0, 1, 1, 0);
    tick();
    rst_n = 1'b0; ea = 0; eb = 0;
    #1 chk_ab("rst_mid", 1, 1, 0, 0);
    chk_cnt("rst_mid");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3 chk_ab("post_rst", 1, 1, 0, 0);
      tick();
    end
    chk_cnt("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
